// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN feature-map memory.
// Word width, address width, bank depth and bank select codes.
package bnn_pkg;

    localparam int WL    = 112;
    localparam int AW    = 5;
    localparam int DEPTH = 28;
    localparam int CW    = $clog2(WL);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WL - 1);

    localparam logic BANK_IMG = 1'b0;
    localparam logic BANK_SCR = 1'b1;

    typedef logic [WL-1:0] bnn_word_t;

endpackage

// File: rtl/bnn_bit_packer.sv
// Bit-serial packer: shifts bits MSB-first into a word and hands the
// finished word to a commit register with a pending flag.
module bnn_bit_packer
    import bnn_pkg::*;
(
    input  logic      iCLK,
    input  logic      iRST,
    input  logic      iCLR,
    input  logic      iBIT_EN,
    input  logic      iBIT,
    input  logic      iRETRY,
    output bnn_word_t oWORD,
    output logic      oPEND
);

    logic [CW-1:0] bitCnt;
    bnn_word_t     shReg;
    bnn_word_t     shNext;
    logic          lastBit;

    assign shNext  = {shReg[WL-2:0], iBIT};
    assign lastBit = iBIT_EN && (bitCnt == LAST_BIT);

    // Shift in bits, capture completed word, hold pending until committed
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bitCnt <= '0;
            shReg  <= '0;
            oWORD  <= '0;
            oPEND  <= 1'b0;
        end else if (iCLR) begin
            bitCnt <= '0;
            shReg  <= '0;
            oWORD  <= '0;
            oPEND  <= 1'b0;
        end else begin
            if (iBIT_EN) begin
                shReg <= shNext;
                if (lastBit) begin
                    bitCnt <= '0;
                    oWORD  <= shNext;
                end else begin
                    bitCnt <= bitCnt + 1'b1;
                end
            end
            if (lastBit) begin
                oPEND <= 1'b1;
            end else if (oPEND && !iRETRY) begin
                oPEND <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bnn_fmap_mem.sv
// Dual-bank binary feature-map memory with bit packer and image preload.
// Define BNN_FMAP_FWD_EN to forward same-edge writes to a matching read.
module bnn_fmap_mem
    import bnn_pkg::*;
(
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCLR,
    input  logic          iRd_EN,
    input  logic          iRd_BANK,
    input  logic [AW-1:0] iADDR,
    output bnn_word_t     oDATA,
    output logic          oVALID,
    input  logic          iBIT_EN,
    input  logic          iBIT,
    input  logic          iWr_BANK,
    output logic [AW-1:0] oWr_ADDR,
    output logic          oWr_DONE,
    output logic          oFULL,
    input  logic          iLD_EN,
    input  logic [AW-1:0] iLD_ADDR,
    input  bnn_word_t     iLD_DATA,
    output logic          oERR
);

    bnn_word_t mem0 [DEPTH];
    bnn_word_t mem1 [DEPTH];

    bnn_word_t pkWord;
    bnn_word_t rdWord;
    logic      pkPend;
    logic      ldOk;
    logic      loadBlk;
    logic      commitTry;
    logic      commitWr;
    logic      wr0;
    logic      wr1;
    logic      rdOk;
    logic      doneD;

    assign ldOk      = iLD_EN && (iLD_ADDR < DEPTH_A);
    assign loadBlk   = ldOk && (iWr_BANK == BANK_IMG);
    assign commitTry = pkPend && !loadBlk && !iCLR;
    assign commitWr  = commitTry && !oFULL;
    assign wr0       = commitWr && (iWr_BANK == BANK_IMG);
    assign wr1       = commitWr && (iWr_BANK == BANK_SCR);
    assign rdOk      = iADDR < DEPTH_A;
    assign oFULL     = (oWr_ADDR == DEPTH_A);

    bnn_bit_packer uPacker (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iCLR    (iCLR),
        .iBIT_EN (iBIT_EN),
        .iBIT    (iBIT),
        .iRETRY  (pkPend && loadBlk),
        .oWORD   (pkWord),
        .oPEND   (pkPend)
    );

    // Bank 0: preload has priority, packed commit otherwise
    always_ff @(posedge iCLK) begin
        if (ldOk) begin
            mem0[iLD_ADDR] <= iLD_DATA;
        end else if (wr0) begin
            mem0[oWr_ADDR] <= pkWord;
        end
    end

    // Bank 1: packed commits only
    always_ff @(posedge iCLK) begin
        if (wr1) begin
            mem1[oWr_ADDR] <= pkWord;
        end
    end

    // Read mux, optionally bypassing a same-edge write
    always_comb begin
        rdWord = '0;
        if (rdOk) begin
            rdWord = (iRd_BANK == BANK_SCR) ? mem1[iADDR] : mem0[iADDR];
`ifdef BNN_FMAP_FWD_EN
            if (iRd_BANK == BANK_SCR) begin
                if (wr1 && (oWr_ADDR == iADDR)) rdWord = pkWord;
            end else begin
                if (ldOk && (iLD_ADDR == iADDR)) begin
                    rdWord = iLD_DATA;
                end else if (wr0 && (oWr_ADDR == iADDR)) begin
                    rdWord = pkWord;
                end
            end
`endif
        end
    end

    // Read port register: one-cycle latency, data held when idle
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA  <= '0;
            oVALID <= 1'b0;
        end else begin
            oVALID <= iRd_EN;
            if (iRd_EN) oDATA <= rdWord;
        end
    end

    // Write pointer, done pulse pipeline and sticky error
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oWr_ADDR <= '0;
            doneD    <= 1'b0;
            oWr_DONE <= 1'b0;
            oERR     <= 1'b0;
        end else if (iCLR) begin
            oWr_ADDR <= '0;
            doneD    <= 1'b0;
            oWr_DONE <= 1'b0;
            oERR     <= 1'b0;
        end else begin
            if (commitWr) oWr_ADDR <= oWr_ADDR + 1'b1;
            doneD    <= commitWr;
            oWr_DONE <= doneD;
            if ((iRd_EN && !rdOk) ||
                (iLD_EN && !ldOk) ||
                (commitTry && oFULL)) begin
                oERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bnn_fmap_mem.sv
// Scoreboard bench for bnn_fmap_mem: reads queue expected words,
// a negedge monitor pops them when oVALID is seen.
module tb_bnn_fmap_mem;
    import bnn_pkg::*;

`ifdef BNN_FMAP_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iCLR = 1'b0;
    logic          iRd_EN = 1'b0;
    logic          iRd_BANK = 1'b0;
    logic [AW-1:0] iADDR = '0;
    bnn_word_t     oDATA;
    logic          oVALID;
    logic          iBIT_EN = 1'b0;
    logic          iBIT = 1'b0;
    logic          iWr_BANK = 1'b0;
    logic [AW-1:0] oWr_ADDR;
    logic          oWr_DONE;
    logic          oFULL;
    logic          iLD_EN = 1'b0;
    logic [AW-1:0] iLD_ADDR = '0;
    bnn_word_t     iLD_DATA = '0;
    logic          oERR;

    int vecs = 0;
    int errs = 0;
    int doneCnt = 0;
    int d0;
    bnn_word_t expQ [$];
    bnn_word_t ones = '1;
    bnn_word_t zero = '0;
    bnn_word_t alt;
    bnn_word_t pw;
    bnn_word_t lw;
    bnn_word_t fw;

    bnn_fmap_mem dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iCLR     (iCLR),
        .iRd_EN   (iRd_EN),
        .iRd_BANK (iRd_BANK),
        .iADDR    (iADDR),
        .oDATA    (oDATA),
        .oVALID   (oVALID),
        .iBIT_EN  (iBIT_EN),
        .iBIT     (iBIT),
        .iWr_BANK (iWr_BANK),
        .oWr_ADDR (oWr_ADDR),
        .oWr_DONE (oWr_DONE),
        .oFULL    (oFULL),
        .iLD_EN   (iLD_EN),
        .iLD_ADDR (iLD_ADDR),
        .iLD_DATA (iLD_DATA),
        .oERR     (oERR)
    );

    always #5 iCLK = ~iCLK;

    function automatic bnn_word_t rep8(input logic [7:0] b);
        return {14{b}};
    endfunction

    task automatic chkW(input string nm, input bnn_word_t act,
                        input bnn_word_t exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkN(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Read scoreboard monitor
    always @(negedge iCLK) begin
        if (!iRST && oVALID) begin
            if (expQ.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL rd_unexpected: got %h want none", oDATA);
            end else begin
                chkW("rd_data", oDATA, expQ.pop_front());
            end
        end
    end

    // Commit pulse counter
    always @(negedge iCLK) begin
        if (!iRST && oWr_DONE) doneCnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic issueRead(input logic b, input logic [AW-1:0] a,
                             input bnn_word_t exp);
        iRd_EN   = 1'b1;
        iRd_BANK = b;
        iADDR    = a;
        expQ.push_back(exp);
        tick(1);
        iRd_EN = 1'b0;
    endtask

    task automatic sendWord(input bnn_word_t w);
        for (int i = WL - 1; i >= 0; i--) begin
            iBIT_EN = 1'b1;
            iBIT    = w[i];
            tick(1);
        end
    endtask

    task automatic doClr();
        iCLR = 1'b1;
        tick(1);
        iCLR = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        alt = {28{4'hA}};
        pw  = rep8(8'hC3);
        lw  = rep8(8'h7E);
        fw  = rep8(8'h5C);

        tick(3);
        iRST = 1'b0;
        @(negedge iCLK);
        chkW("rst_data", oDATA, zero);
        chkN("rst_valid", int'(oVALID), 0);
        chkN("rst_wraddr", int'(oWr_ADDR), 0);
        chkN("rst_done", int'(oWr_DONE), 0);
        chkN("rst_full", int'(oFULL), 0);
        chkN("rst_err", int'(oERR), 0);
        tick(1);

        for (int a = 0; a < DEPTH; a++) begin
            iLD_EN   = 1'b1;
            iLD_ADDR = AW'(a);
            iLD_DATA = rep8(8'(a));
            tick(1);
        end
        iLD_EN = 1'b0;
        issueRead(BANK_IMG, 5'd5, rep8(8'd5));
        chkN("err_clean", int'(oERR), 0);
        issueRead(BANK_IMG, 5'd30, zero);
        @(negedge iCLK);
        chkN("err_oob_rd", int'(oERR), 1);
        tick(1);
        doClr();
        @(negedge iCLK);
        chkN("err_clr", int'(oERR), 0);
        tick(1);

        iWr_BANK = BANK_SCR;
        d0 = doneCnt;
        sendWord(alt);
        iBIT_EN = 1'b0;
        @(negedge iCLK);
        chkN("t0_addr", int'(oWr_ADDR), 0);
        chkN("t0_done", int'(oWr_DONE), 0);
        @(negedge iCLK);
        chkN("t1_addr", int'(oWr_ADDR), 1);
        chkN("t1_done", int'(oWr_DONE), 0);
        @(negedge iCLK);
        chkN("t2_done", int'(oWr_DONE), 1);
        tick(2);
        chkN("alt_pulses", doneCnt - d0, 1);
        issueRead(BANK_SCR, 5'd0, alt);

        sendWord(zero);
        sendWord(zero);
        iBIT_EN = 1'b0;
        tick(3);
        doClr();
        sendWord(zero);
        sendWord(zero);
        sendWord(ones);
        iBIT_EN = 1'b0;
        issueRead(BANK_SCR, 5'd2, FWD ? ones : zero);
        tick(2);
        issueRead(BANK_SCR, 5'd2, ones);

        iLD_EN   = 1'b1;
        iLD_ADDR = 5'd2;
        iLD_DATA = ones;
        issueRead(BANK_IMG, 5'd2, FWD ? ones : rep8(8'd2));
        iLD_EN = 1'b0;
        issueRead(BANK_IMG, 5'd2, ones);

        chkN("col_start", int'(oWr_ADDR), 3);
        iWr_BANK = BANK_IMG;
        sendWord(pw);
        iBIT_EN  = 1'b0;
        iLD_EN   = 1'b1;
        iLD_ADDR = 5'd7;
        iLD_DATA = lw;
        tick(1);
        iLD_EN = 1'b0;
        @(negedge iCLK);
        chkN("col_held", int'(oWr_ADDR), 3);
        tick(1);
        chkN("col_commit", int'(oWr_ADDR), 4);
        chkN("col_err", int'(oERR), 0);
        issueRead(BANK_IMG, 5'd3, pw);
        issueRead(BANK_IMG, 5'd7, lw);
        tick(1);

        iWr_BANK = BANK_SCR;
        doClr();
        d0 = doneCnt;
        for (int k = 0; k < DEPTH; k++) begin
            sendWord(rep8(8'(8'h40 + k)));
        end
        sendWord(ones);
        iBIT_EN = 1'b0;
        tick(4);
        chkN("fill_pulses", doneCnt - d0, DEPTH);
        chkN("fill_full", int'(oFULL), 1);
        chkN("fill_addr", int'(oWr_ADDR), DEPTH);
        chkN("fill_err", int'(oERR), 1);
        for (int k = 0; k < DEPTH; k++) begin
            issueRead(BANK_SCR, AW'(k), rep8(8'(8'h40 + k)));
        end
        tick(2);

        for (int i = 0; i < 50; i++) begin
            iBIT_EN = 1'b1;
            iBIT    = 1'b1;
            tick(1);
        end
        iBIT_EN = 1'b0;
        iRST    = 1'b1;
        tick(1);
        iRST = 1'b0;
        @(negedge iCLK);
        chkN("mid_rst_addr", int'(oWr_ADDR), 0);
        chkN("mid_rst_full", int'(oFULL), 0);
        chkN("mid_rst_err", int'(oERR), 0);
        tick(1);
        d0 = doneCnt;
        sendWord(fw);
        iBIT_EN = 1'b0;
        tick(4);
        chkN("fresh_addr", int'(oWr_ADDR), 1);
        chkN("fresh_pulses", doneCnt - d0, 1);
        issueRead(BANK_SCR, 5'd0, fw);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) tick(1);
        chkN("drain", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
